// File: rtl/dmem_responder.sv
// Single-port data memory responder for a RISC-V load/store initiator.
// Requests are serviced one at a time with a fixed latency before the response.
module dmem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h01000000,
    parameter int          DEPTH_BYTES = 1048576,
    parameter int          LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          WORDS    = DEPTH_BYTES / 4;
    localparam int          IW       = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
    localparam logic [31:0] DEPTH32  = 32'(DEPTH_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        access;

    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        cap_write;
    logic [2:0]  cap_funct3;

    logic [31:0] mem [WORDS];

    // With LATENCY=1 the access happens on the accept edge, before capture.
    logic [31:0] src_addr;
    logic [31:0] src_wdata;
    logic        src_write;
    logic [2:0]  src_funct3;

    assign src_addr   = (state == IDLE) ? req_addr   : cap_addr;
    assign src_wdata  = (state == IDLE) ? req_wdata  : cap_wdata;
    assign src_write  = (state == IDLE) ? req_write  : cap_write;
    assign src_funct3 = (state == IDLE) ? req_funct3 : cap_funct3;

    logic [31:0] offset;
    logic [31:0] size;
    logic        funct_ok;
    logic        align_ok;
    logic        acc_err;
    logic [IW-1:0] word_idx;
    logic [31:0] rd_word;
    logic [31:0] rd_shift;
    logic [31:0] load_val;
    logic [31:0] wlane;
    logic [3:0]  be;

    assign offset   = src_addr - BASE_ADDR;
    assign word_idx = offset[IW+1:2];
    assign rd_word  = mem[word_idx];
    assign rd_shift = rd_word >> {offset[1:0], 3'b000};
    assign wlane    = src_wdata << {offset[1:0], 3'b000};

    always_comb begin
        size     = 32'd4;
        funct_ok = 1'b0;
        align_ok = 1'b1;
        be       = 4'b0000;
        load_val = 32'h0;
        case (src_funct3[1:0])
            2'd0: begin
                size = 32'd1;
                be   = 4'b0001 << offset[1:0];
            end
            2'd1: begin
                size     = 32'd2;
                align_ok = (src_addr[0] == 1'b0);
                be       = 4'b0011 << offset[1:0];
            end
            default: begin
                size     = 32'd4;
                align_ok = (src_addr[1:0] == 2'b00);
                be       = 4'b1111;
            end
        endcase
        if (src_write)
            funct_ok = (src_funct3 == 3'd0) || (src_funct3 == 3'd1) || (src_funct3 == 3'd2);
        else
            funct_ok = (src_funct3 == 3'd0) || (src_funct3 == 3'd1) || (src_funct3 == 3'd2) ||
                       (src_funct3 == 3'd4) || (src_funct3 == 3'd5);
        case (src_funct3)
            3'd0:    load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'd1:    load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'd2:    load_val = rd_shift;
            3'd4:    load_val = {24'h0, rd_shift[7:0]};
            3'd5:    load_val = {16'h0, rd_shift[15:0]};
            default: load_val = 32'h0;
        endcase
    end

    // Addresses below BASE_ADDR wrap to a huge offset and fail this check.
    assign acc_err = !(funct_ok && align_ok && (offset <= (DEPTH32 - size)));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        access    = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (CNT_INIT == 4'd0) begin
                        state_n = RESP;
                        cnt_n   = 4'd0;
                        access  = 1'b1;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt <= 4'd1) begin
                    state_n = RESP;
                    cnt_n   = 4'd0;
                    access  = 1'b1;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cap_addr   <= 32'h0;
            cap_wdata  <= 32'h0;
            cap_write  <= 1'b0;
            cap_funct3 <= 3'd0;
        end else if (state == IDLE && req_valid) begin
            cap_addr   <= req_addr;
            cap_wdata  <= req_wdata;
            cap_write  <= req_write;
            cap_funct3 <= req_funct3;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else if (access) begin
            rsp_err   <= acc_err;
            rsp_rdata <= (acc_err || src_write) ? 32'h0 : load_val;
        end else if (state == RESP && rsp_ready) begin
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clock) begin
        if (reset && access && src_write && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b])
                    mem[word_idx][8*b +: 8] <= wlane[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder at default parameters.
module tb_dmem_responder;

    localparam int          LATENCY = 2;
    localparam logic [31:0] BASE    = 32'h01000000;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int tests  = 0;
    int failed = 0;
    int lat;

    dmem_responder #(
        .BASE_ADDR(BASE),
        .DEPTH_BYTES(1048576),
        .LATENCY(LATENCY)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr(req_addr),
        .req_write(req_write),
        .req_funct3(req_funct3),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for rsp_valid; lat is the cycle index of the response relative to the accept cycle.
    task automatic wait_response();
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clock);
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic apply_stimulus(input string tag, input logic w, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] d,
                                  input logic [31:0] exp_rdata, input logic exp_err);
        @(negedge clock);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        check_output({tag, " req_ready"}, {31'h0, req_ready}, 32'h1);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        wait_response();
        check_output({tag, " latency"}, lat, LATENCY);
        check_output({tag, " rdata"}, rsp_rdata, exp_rdata);
        check_output({tag, " err"}, {31'h0, rsp_err}, {31'h0, exp_err});
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;
        check_output({tag, " rsp_valid drop"}, {31'h0, rsp_valid}, 32'h0);
    endtask

    initial begin
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 32'h0;
        req_write  = 1'b0;
        req_funct3 = 3'd0;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b0;

        #3;
        check_output("reset req_ready", {31'h0, req_ready}, 32'h1);
        check_output("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check_output("reset rdata", rsp_rdata, 32'h0);
        check_output("reset err", {31'h0, rsp_err}, 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Basic word store/load and sub-word loads.
        apply_stimulus("SW base", 1'b1, 3'd2, BASE, 32'hDEADBEEF, 32'h0, 1'b0);
        apply_stimulus("LW base", 1'b0, 3'd2, BASE, 32'h0, 32'hDEADBEEF, 1'b0);
        apply_stimulus("LB +3", 1'b0, 3'd0, BASE + 32'd3, 32'h0, 32'hFFFFFFDE, 1'b0);
        apply_stimulus("LBU +3", 1'b0, 3'd4, BASE + 32'd3, 32'h0, 32'h000000DE, 1'b0);
        apply_stimulus("LH +0", 1'b0, 3'd1, BASE, 32'h0, 32'hFFFFBEEF, 1'b0);
        apply_stimulus("LHU +2", 1'b0, 3'd5, BASE + 32'd2, 32'h0, 32'h0000DEAD, 1'b0);
        apply_stimulus("SB +1", 1'b1, 3'd0, BASE + 32'd1, 32'hFFFFFF12, 32'h0, 1'b0);
        apply_stimulus("LW after SB", 1'b0, 3'd2, BASE, 32'h0, 32'hDEAD12EF, 1'b0);

        // Error cases, then confirm storage untouched.
        apply_stimulus("LW misaligned", 1'b0, 3'd2, BASE + 32'd2, 32'h0, 32'h0, 1'b1);
        apply_stimulus("SH misaligned", 1'b1, 3'd1, BASE + 32'd1, 32'h00007777, 32'h0, 1'b1);
        apply_stimulus("LW below base", 1'b0, 3'd2, 32'h00FFFFFC, 32'h0, 32'h0, 1'b1);
        apply_stimulus("LW past end", 1'b0, 3'd2, 32'h01100000, 32'h0, 32'h0, 1'b1);
        apply_stimulus("funct3 3", 1'b0, 3'd3, BASE, 32'h0, 32'h0, 1'b1);
        apply_stimulus("store funct3 4", 1'b1, 3'd4, BASE, 32'h11111111, 32'h0, 1'b1);
        apply_stimulus("SB below base", 1'b1, 3'd0, 32'h00FFFFFF, 32'h0, 32'h0, 1'b1);
        apply_stimulus("LW unchanged", 1'b0, 3'd2, BASE, 32'h0, 32'hDEAD12EF, 1'b0);

        // Last served word and halfword at the top boundary.
        apply_stimulus("SW last", 1'b1, 3'd2, 32'h010FFFFC, 32'hCAFEF00D, 32'h0, 1'b0);
        apply_stimulus("LW last", 1'b0, 3'd2, 32'h010FFFFC, 32'h0, 32'hCAFEF00D, 1'b0);
        apply_stimulus("LH top", 1'b0, 3'd1, 32'h010FFFFE, 32'h0, 32'hFFFFCAFE, 1'b0);

        // Backpressure: response held while a new request waits.
        @(negedge clock);
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = BASE;
        @(posedge clock);
        @(negedge clock);
        req_funct3 = 3'd4;
        req_addr   = BASE + 32'd3;
        wait_response();
        check_output("stall latency", lat, LATENCY);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            @(negedge clock);
            check_output($sformatf("stall%0d rsp_valid", i), {31'h0, rsp_valid}, 32'h1);
            check_output($sformatf("stall%0d rdata", i), rsp_rdata, 32'hDEAD12EF);
            check_output($sformatf("stall%0d err", i), {31'h0, rsp_err}, 32'h0);
            check_output($sformatf("stall%0d req_ready", i), {31'h0, req_ready}, 32'h0);
        end
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;
        check_output("post stall rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check_output("post stall req_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        wait_response();
        check_output("queued latency", lat, LATENCY);
        check_output("queued rdata", rsp_rdata, 32'h000000DE);
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;

        // Reset during WAIT of a store aborts it.
        @(negedge clock);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = BASE;
        req_wdata  = 32'h00000055;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        check_output("pre-abort req_ready", {31'h0, req_ready}, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        check_output("abort req_ready", {31'h0, req_ready}, 32'h1);
        check_output("abort rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check_output("abort rdata", rsp_rdata, 32'h0);
        check_output("abort err", {31'h0, rsp_err}, 32'h0);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            @(negedge clock);
            check_output($sformatf("no stray rsp %0d", i), {31'h0, rsp_valid}, 32'h0);
        end
        apply_stimulus("LW after abort", 1'b0, 3'd2, BASE, 32'h0, 32'hDEAD12EF, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
